regfile_scoreboard: RTL and testbench

- Parametrised integer register file with N read ports, one write port, optional write-to-read bypass, and a per-register busy scoreboard.
- Sits in the core datapath between decode/issue and writeback.
- Issue reserves a destination register. Writeback clears the reservation.
- Read ports report both data and busy status, so the control FSM can stall on RAW hazards without a separate hazard unit.

---
 rtl/regfile_scoreboard_pkg.sv | 13 +
 rtl/regfile_read_port.sv | 36 +++
 rtl/regfile_scoreboard.sv | 87 ++++++++
 tb/tb_regfile_scoreboard.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared core types and defaults for the register file / scoreboard slice.
package regfile_scoreboard_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned NREGS_DEFAULT = 32;
  localparam int unsigned AW_DEFAULT    = $clog2(NREGS_DEFAULT);

  typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
  typedef logic [XLEN_DEFAULT-1:0] xword_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: x0 forcing, same-cycle write bypass and busy gating.
module regfile_read_port #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] stored,
  input  logic            busy_bit,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_din,
  output logic [XLEN-1:0] dout_c,
  output logic            busy_c
);

  logic is_zero_c;
  logic hit_c;

  assign is_zero_c = (addr == AW'(0));
  assign hit_c     = (BYPASS != 0) && we && (wr_addr == addr);

  // A bypassed write satisfies the reservation in the same cycle.
  always_comb begin
    dout_c = stored;
    busy_c = busy_bit;
    if (is_zero_c) begin
      dout_c = '0;
      busy_c = 1'b0;
    end else if (hit_c) begin
      dout_c = wr_din;
      busy_c = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with N read ports, one write port and a per-register busy scoreboard.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned NREGS  = NREGS_DEFAULT,
  parameter int unsigned NRD    = 2,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_dout,
  output logic [NRD-1:0]      rd_busy,
  input  logic                we,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_din,
  input  logic                resv_en,
  input  logic [AW-1:0]       resv_addr,
  input  logic                flush,
  output logic                any_busy
);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             wr_ok_c;
  logic             resv_ok_c;

  assign wr_ok_c   = we && (wr_addr != AW'(REG_ZERO));
  assign resv_ok_c = resv_en && (resv_addr != AW'(REG_ZERO));

  // Data storage; x0 is never written so it stays zero from reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(NREGS); r++) begin
        mem[r] <= '0;
      end
    end else if (wr_ok_c) begin
      mem[wr_addr] <= wr_din;
    end
  end

  // Scoreboard next state: writeback clears, flush clears all, a new reservation wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok_c) begin
      busy_nxt[wr_addr] = 1'b0;
    end
    if (flush) begin
      busy_nxt = '0;
    end
    if (resv_ok_c) begin
      busy_nxt[resv_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign any_busy = |busy;

  for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
    regfile_read_port #(
      .XLEN   (XLEN),
      .AW     (AW),
      .BYPASS (BYPASS)
    ) u_port (
      .addr     (rd_addr[i*AW +: AW]),
      .stored   (mem[rd_addr[i*AW +: AW]]),
      .busy_bit (busy[rd_addr[i*AW +: AW]]),
      .we       (we),
      .wr_addr  (wr_addr),
      .wr_din   (wr_din),
      .dout_c   (rd_dout[i*XLEN +: XLEN]),
      .busy_c   (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed plus randomized checks of regfile_scoreboard (BYPASS=1 and BYPASS=0) against a reference model.
module tb_regfile_scoreboard;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD = 2;
  localparam int unsigned AW = 5;

  logic                clk;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic                we;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_din;
  logic                resv_en;
  logic [AW-1:0]       resv_addr;
  logic                flush;

  logic [NRD*XLEN-1:0] dout_b, dout_n;
  logic [NRD-1:0]      busy_b, busy_n;
  logic                any_b, any_n;

  regfile_scoreboard #(.BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_dout(dout_b), .rd_busy(busy_b),
    .we(we), .wr_addr(wr_addr), .wr_din(wr_din), .resv_en(resv_en),
    .resv_addr(resv_addr), .flush(flush), .any_busy(any_b)
  );

  regfile_scoreboard #(.BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_dout(dout_n), .rd_busy(busy_n),
    .we(we), .wr_addr(wr_addr), .wr_din(wr_din), .resv_en(resv_en),
    .resv_addr(resv_addr), .flush(flush), .any_busy(any_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Architectural reference state.
  logic [XLEN-1:0] model_mem [NREGS];
  bit              model_busy [NREGS];

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input int a, input bit byp);
    if (a == 0) return '0;
    if (byp && we && int'(wr_addr) == a) return wr_din;
    return model_mem[a];
  endfunction

  function automatic logic exp_busy(input int a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && we && int'(wr_addr) == a) return 1'b0;
    return model_busy[a];
  endfunction

  function automatic logic exp_any();
    for (int r = 0; r < int'(NREGS); r++) if (model_busy[r]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_all();
    for (int p = 0; p < int'(NRD); p++) begin
      int a;
      a = int'(rd_addr[p*AW +: AW]);
      chk($sformatf("byp_dout%0d_x%0d", p, a), dout_b[p*XLEN +: XLEN], exp_rd(a, 1'b1));
      chk($sformatf("nob_dout%0d_x%0d", p, a), dout_n[p*XLEN +: XLEN], exp_rd(a, 1'b0));
      chk($sformatf("byp_busy%0d_x%0d", p, a), 32'(busy_b[p]), 32'(exp_busy(a, 1'b1)));
      chk($sformatf("nob_busy%0d_x%0d", p, a), 32'(busy_n[p]), 32'(exp_busy(a, 1'b0)));
    end
    chk("byp_any_busy", 32'(any_b), 32'(exp_any()));
    chk("nob_any_busy", 32'(any_n), 32'(exp_any()));
  endtask

  task automatic model_update();
    if (rst) begin
      for (int r = 0; r < int'(NREGS); r++) begin
        model_mem[r] = '0;
        model_busy[r] = 1'b0;
      end
    end else begin
      if (we && wr_addr != 0) begin
        model_mem[wr_addr] = wr_din;
        model_busy[wr_addr] = 1'b0;
      end
      if (flush) for (int r = 0; r < int'(NREGS); r++) model_busy[r] = 1'b0;
      if (resv_en && resv_addr != 0) model_busy[resv_addr] = 1'b1;
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; checks land mid-cycle.
  task automatic cyc();
    #2;
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; we = 1'b0; wr_addr = '0; wr_din = '0;
    resv_en = 1'b0; resv_addr = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    for (int r = 0; r < int'(NREGS); r++) begin
      model_mem[r] = '0;
      model_busy[r] = 1'b0;
    end
    idle();
    rd_addr = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_update();

    // Random traffic, then a two-cycle reset must wipe everything.
    for (int k = 0; k < 10; k++) begin
      idle();
      we = 1'b1; wr_addr = AW'($urandom_range(1, 31)); wr_din = $urandom();
      resv_en = 1'b1; resv_addr = AW'($urandom_range(1, 31));
      set_rd($urandom_range(0, 31), $urandom_range(0, 31));
      cyc();
    end
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    idle();
    for (int a = 0; a < int'(NREGS); a++) begin
      set_rd(a, a);
      #1;
      chk("rst_dout", dout_b[31:0] | dout_n[31:0], 32'h0);
      chk("rst_busy", 32'({busy_b, busy_n, any_b, any_n}), 32'h0);
      cyc();
    end

    // Write/read and x0.
    we = 1'b1; wr_addr = 5; wr_din = 32'hDEADBEEF;
    cyc();
    idle(); set_rd(5, 0);
    #1;
    chk("wr5_port0", dout_b[31:0], 32'hDEADBEEF);
    chk("wr5_port1_x0", dout_b[63:32], 32'h0);
    cyc();
    we = 1'b1; wr_addr = 0; wr_din = 32'h1234; set_rd(0, 0);
    cyc();
    idle();
    #1;
    chk("x0_ignored", dout_b[31:0], 32'h0);
    cyc();

    // Bypass versus stored-only read.
    we = 1'b1; wr_addr = 7; wr_din = 32'hA5A5A5A5; set_rd(7, 5);
    #1;
    chk("bypass_dout", dout_b[31:0], 32'hA5A5A5A5);
    chk("bypass_busy", 32'(busy_b[0]), 32'h0);
    chk("nobypass_old", dout_n[31:0], 32'h0);
    cyc();
    idle();
    #1;
    chk("after_wr7_byp", dout_b[31:0], 32'hA5A5A5A5);
    chk("after_wr7_nob", dout_n[31:0], 32'hA5A5A5A5);
    cyc();

    // Reserve then write back x3.
    resv_en = 1'b1; resv_addr = 3; set_rd(3, 0);
    #1;
    chk("resv_any_latency", 32'(any_b), 32'h0);
    cyc();
    idle();
    #1;
    chk("x3_busy", 32'(busy_b[0]), 32'h1);
    chk("x3_any", 32'(any_b), 32'h1);
    cyc();
    we = 1'b1; wr_addr = 3; wr_din = 32'h11;
    cyc();
    idle();
    #1;
    chk("x3_cleared", 32'({busy_b[0], any_b}), 32'h0);
    chk("x3_data", dout_b[31:0], 32'h11);
    cyc();

    // Write and reservation collide on x9.
    resv_en = 1'b1; resv_addr = 9; set_rd(9, 3);
    cyc();
    we = 1'b1; wr_addr = 9; wr_din = 32'h22; resv_en = 1'b1; resv_addr = 9;
    cyc();
    idle();
    #1;
    chk("x9_busy", 32'(busy_n[0]), 32'h1);
    chk("x9_data", dout_n[31:0], 32'h22);
    cyc();

    // Flush with a concurrent reservation, then a mid-sequence reset.
    for (int r = 1; r <= 4; r++) begin
      we = 1'b1; wr_addr = AW'(r); wr_din = 32'h100 + 32'(r);
      cyc();
    end
    idle();
    resv_en = 1'b1; resv_addr = 1; cyc();
    resv_addr = 2; cyc();
    resv_addr = 4; cyc();
    idle();
    flush = 1'b1; resv_en = 1'b1; resv_addr = 6;
    cyc();
    idle(); set_rd(1, 6);
    #1;
    chk("flush_x1", 32'(busy_b[0]), 32'h0);
    chk("flush_x6", 32'(busy_b[1]), 32'h1);
    chk("flush_x1_data", dout_b[31:0], 32'h101);
    cyc();
    set_rd(2, 4);
    #1;
    chk("flush_x2x4", 32'(busy_b), 32'h0);
    chk("flush_x4_data", dout_b[63:32], 32'h104);
    cyc();
    set_rd(9, 6);
    #1;
    chk("flush_x9", 32'(busy_b[0]), 32'h0);
    cyc();
    resv_en = 1'b1; resv_addr = 5;
    cyc();
    idle(); rst = 1'b1;
    cyc();
    idle();
    #1;
    chk("rst_mid_any", 32'({any_b, any_n}), 32'h0);
    cyc();

    // Randomized traffic against the reference model.
    for (int k = 0; k < 600; k++) begin
      idle();
      rst       = ($urandom_range(0, 79) == 0);
      we        = ($urandom_range(0, 1) == 0);
      wr_addr   = AW'($urandom_range(0, 7));
      wr_din    = $urandom();
      resv_en   = ($urandom_range(0, 2) == 0);
      resv_addr = AW'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 24) == 0);
      set_rd($urandom_range(0, 7), $urandom_range(0, 31));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
